// File: rtl/if_fetch_queue_if.sv
// Bundle of the instruction-memory and decode-side handshakes of the fetch queue.
//   imem_req/imem_addr   : fetch request and word address (fetch queue -> imem)
//   imem_ack/imem_rdata  : request completion and instruction word (imem -> fetch queue)
//   redirect/redirect_pc : flush and restart from execute
//   id_valid/instruction/PC, id_ready : head-entry handshake towards decode
// master = fetch queue side, slave = memory/execute/decode environment.
interface if_fetch_queue_if #(
    parameter int WIDTH = 64
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      instruction;
    logic [WIDTH-1:0] PC;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        output id_valid, instruction, PC,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        input  id_valid, instruction, PC,
        output id_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Decoupled instruction-fetch front end. Issues word fetches over a req/ack
// handshake, buffers up to two {PC, instruction} pairs and hands them to decode
// over valid/ready. Redirects flush the buffer and restart fetch; a request that
// is still outstanding at redirect time is drained and its data dropped.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : if_fetch_queue_if.master (imem req/ack, redirect, decode valid/ready)
module if_fetch_queue #(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_queue_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] fetch_pc, fetch_pc_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] pc_mem  [2];
    logic [31:0]      ins_mem [2];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count;
    logic             deq, enq, flush, space, ack;
    logic [WIDTH-1:0] next_addr, redir_pc;

    assign ack       = bus.imem_ack;
    assign redir_pc  = {bus.redirect_pc[WIDTH-1:2], 2'b00};
    assign next_addr = addr_q + WIDTH'(4);   // wraps modulo 2^WIDTH
    assign deq       = (count != 2'd0) && bus.id_ready;
    // Room for one more entry once this cycle's dequeue is accounted for.
    assign space     = !((count == 2'd2) && !deq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d    = state;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc;
        flush      = 1'b0;
        enq        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redir_pc;
                    addr_d     = redir_pc;
                    state_d    = REQ;
                end else if (space) begin
                    addr_d  = fetch_pc;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redir_pc;
                    // Returning data belongs to the old stream; reissue at the
                    // target right away if the transaction closed, else drain it.
                    if (ack) addr_d  = redir_pc;
                    else     state_d = DRAIN;
                end else if (ack) begin
                    enq        = 1'b1;
                    fetch_pc_d = next_addr;
                    // REQ only ever runs with count <= 1, so the post-enqueue
                    // count stays below 2 unless one entry is sitting un-dequeued.
                    if ((count == 2'd0) || deq) addr_d  = next_addr;
                    else                        state_d = IDLE;
                end
            end
            DRAIN: begin
                if (bus.redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redir_pc;
                end else if (ack) begin
                    addr_d  = fetch_pc;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            addr_q     <= '0;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            pc_mem[0]  <= '0;
            pc_mem[1]  <= '0;
            ins_mem[0] <= '0;
            ins_mem[1] <= '0;
        end else begin
            fetch_pc <= fetch_pc_d;
            addr_q   <= addr_d;
            if (flush) begin
                // Redirect wins over a same-cycle dequeue; enq is never set here.
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                count <= count + {1'b0, enq} - {1'b0, deq};
                if (deq) rd_ptr <= ~rd_ptr;
                if (enq) begin
                    wr_ptr          <= ~wr_ptr;
                    pc_mem[wr_ptr]  <= addr_q;
                    ins_mem[wr_ptr] <= bus.imem_rdata;
                end
            end
        end
    end

    assign bus.imem_req    = (state != IDLE);
    assign bus.imem_addr   = addr_q;
    assign bus.id_valid    = (count != 2'd0);
    assign bus.instruction = ins_mem[rd_ptr];
    assign bus.PC          = pc_mem[rd_ptr];
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: startup streaming, backpressure, wait
// states, redirects (outstanding, coincident, in DRAIN), PC wrap, async reset.
module tb_if_fetch_queue;
    localparam int          WIDTH  = 64;
    localparam logic [63:0] RST_PC = 64'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // imem model controls: ack after ack_wait cycles of req, or forced ack
    int   ack_wait  = 0;
    bit   ack_en    = 1'b1;
    bit   ack_force = 1'b0;
    int   wait_cnt;

    if_fetch_queue_if #(.WIDTH(WIDTH)) bus ();

    if_fetch_queue #(.WIDTH(WIDTH), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0013;
    endfunction

    assign bus.imem_rdata = word(bus.imem_addr);
    assign bus.imem_ack   = bus.imem_req && (ack_force || (ack_en && wait_cnt >= ack_wait));

    always @(posedge clk or posedge rst) begin
        if (rst)                           wait_cnt <= 0;
        else if (bus.imem_req && bus.imem_ack) wait_cnt <= 0;
        else if (bus.imem_req)             wait_cnt <= wait_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.id_valid); end
        checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.instruction); end
        checks++; if (bus.PC !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.PC); end
    endtask

    task automatic test_startup();
        logic [63:0] e;
        ack_en = 1; ack_wait = 0; ack_force = 0; bus.id_ready = 1'b1; bus.redirect = 1'b0;
        do_reset();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL startup_idle_req got %b want 0", bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin errors++; $display("FAIL startup_first_req got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, RST_PC); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL startup_early_valid got %b want 0", bus.id_valid); end
        for (int k = 0; k < 6; k++) begin
            tick();
            e = RST_PC + 64'(4 * k);
            checks++;
            if (bus.id_valid !== 1'b1 || bus.PC !== e || bus.instruction !== word(e)) begin
                errors++; $display("FAIL startup_stream k=%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k, bus.id_valid, bus.PC, bus.instruction, e, word(e));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        ack_en = 1; ack_wait = 0; bus.id_ready = 1'b0;
        do_reset();
        tick(); tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h104) begin errors++; $display("FAIL bp_second_req got %b/%h want 1/104", bus.imem_req, bus.imem_addr); end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (bus.id_valid !== 1'b1 || bus.PC !== 64'h100 || bus.imem_req !== 1'b0) begin
                errors++; $display("FAIL bp_hold k=%0d got v=%b pc=%h req=%b want v=1 pc=100 req=0", k, bus.id_valid, bus.PC, bus.imem_req);
            end
        end
        bus.id_ready = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h108) begin errors++; $display("FAIL bp_resume_req got %b/%h want 1/108", bus.imem_req, bus.imem_addr); end
        for (int k = 0; k < 4; k++) begin
            e = 64'h104 + 64'(4 * k);
            checks++;
            if (bus.id_valid !== 1'b1 || bus.PC !== e) begin
                errors++; $display("FAIL bp_release k=%0d got v=%b pc=%h want v=1 pc=%h", k, bus.id_valid, bus.PC, e);
            end
            tick();
        end
    endtask

    task automatic test_wait_states();
        logic [63:0] ea, ep;
        logic        ev;
        ack_en = 1; ack_wait = 3; bus.id_ready = 1'b1;
        do_reset();
        tick();
        for (int c = 2; c <= 13; c++) begin
            tick();
            ea = 64'h100 + 64'(4 * ((c - 1) / 4));
            ev = (c >= 5) && (c % 4 == 1);
            ep = 64'h100 + 64'(4 * ((c - 5) / 4));
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== ea) begin
                errors++; $display("FAIL wait_addr c=%0d got req=%b addr=%h want req=1 addr=%h", c, bus.imem_req, bus.imem_addr, ea);
            end
            checks++;
            if (bus.id_valid !== ev || (ev && bus.PC !== ep)) begin
                errors++; $display("FAIL wait_valid c=%0d got v=%b pc=%h want v=%b pc=%h", c, bus.id_valid, bus.PC, ev, ep);
            end
        end
        ack_wait = 0;
    endtask

    task automatic test_redirect_outstanding();
        ack_en = 0; ack_force = 1; bus.id_ready = 1'b1;
        do_reset();
        tick(); tick(); tick();
        ack_force = 0;
        checks++; if (bus.imem_addr !== 64'h108 || bus.PC !== 64'h104) begin errors++; $display("FAIL ro_pre got addr=%h pc=%h want 108/104", bus.imem_addr, bus.PC); end
        tick();
        checks++; if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h108) begin errors++; $display("FAIL ro_pending got v=%b req=%b addr=%h want 0/1/108", bus.id_valid, bus.imem_req, bus.imem_addr); end
        bus.redirect = 1'b1; bus.redirect_pc = 64'h2002;
        tick();
        bus.redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h108 || bus.id_valid !== 1'b0) begin
                errors++; $display("FAIL ro_drain k=%0d got req=%b addr=%h v=%b want 1/108/0", k, bus.imem_req, bus.imem_addr, bus.id_valid);
            end
            if (k == 0) tick();
        end
        ack_force = 1;
        tick();
        checks++; if (bus.imem_addr !== 64'h2000 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL ro_target_req got addr=%h v=%b want 2000/0", bus.imem_addr, bus.id_valid); end
        tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.PC !== 64'h2000 || bus.instruction !== word(64'h2000)) begin errors++; $display("FAIL ro_target got v=%b pc=%h ins=%h want 1/2000/%h", bus.id_valid, bus.PC, bus.instruction, word(64'h2000)); end
        ack_force = 0; ack_en = 1;
    endtask

    task automatic test_redirect_coincident();
        ack_en = 1; ack_wait = 0; bus.id_ready = 1'b1;
        do_reset();
        tick(); tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.PC !== 64'h100) begin errors++; $display("FAIL rc_pre got v=%b pc=%h want 1/100", bus.id_valid, bus.PC); end
        bus.redirect = 1'b1; bus.redirect_pc = 64'h3000;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h3000) begin errors++; $display("FAIL rc_flush got v=%b req=%b addr=%h want 0/1/3000", bus.id_valid, bus.imem_req, bus.imem_addr); end
        tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.PC !== 64'h3000) begin errors++; $display("FAIL rc_target got v=%b pc=%h want 1/3000", bus.id_valid, bus.PC); end
        tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.PC !== 64'h3004) begin errors++; $display("FAIL rc_next got v=%b pc=%h want 1/3004", bus.id_valid, bus.PC); end
    endtask

    task automatic test_redirect_in_drain();
        ack_en = 0; ack_force = 0; bus.id_ready = 1'b1;
        do_reset();
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) begin errors++; $display("FAIL rd_req got %b/%h want 1/100", bus.imem_req, bus.imem_addr); end
        bus.redirect = 1'b1; bus.redirect_pc = 64'h4000;
        tick();
        bus.redirect_pc = 64'h5008;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL rd_drain got req=%b addr=%h v=%b want 1/100/0", bus.imem_req, bus.imem_addr, bus.id_valid); end
        ack_force = 1;
        tick();
        checks++; if (bus.imem_addr !== 64'h5008 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL rd_last_target_req got addr=%h v=%b want 5008/0", bus.imem_addr, bus.id_valid); end
        tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.PC !== 64'h5008) begin errors++; $display("FAIL rd_last_target got v=%b pc=%h want 1/5008", bus.id_valid, bus.PC); end
        ack_force = 0; ack_en = 1;
    endtask

    task automatic test_wrap();
        ack_en = 1; ack_wait = 0; bus.id_ready = 1'b1;
        do_reset();
        bus.redirect = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_req got %h want fffffffffffffffc", bus.imem_addr); end
        tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.PC !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_top got v=%b pc=%h want 1/fffffffffffffffc", bus.id_valid, bus.PC); end
        tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.PC !== 64'h0 || bus.instruction !== word(64'h0)) begin errors++; $display("FAIL wrap_zero got v=%b pc=%h ins=%h want 1/0/%h", bus.id_valid, bus.PC, bus.instruction, word(64'h0)); end
        tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.PC !== 64'h4) begin errors++; $display("FAIL wrap_four got v=%b pc=%h want 1/4", bus.id_valid, bus.PC); end
    endtask

    task automatic test_async_reset();
        ack_en = 1; ack_wait = 0; bus.id_ready = 1'b1;
        do_reset();
        tick(); tick(); tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL ar_pre got v=%b req=%b want 1/1", bus.id_valid, bus.imem_req); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 64'h0 || bus.id_valid !== 1'b0 || bus.instruction !== 32'h0 || bus.PC !== 64'h0) begin
            errors++; $display("FAIL ar_outputs got req=%b addr=%h v=%b ins=%h pc=%h want all 0", bus.imem_req, bus.imem_addr, bus.id_valid, bus.instruction, bus.PC);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready    = 1'b1;
        test_reset();
        test_startup();
        test_backpressure();
        test_wait_states();
        test_redirect_outstanding();
        test_redirect_coincident();
        test_redirect_in_drain();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish before 100000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Decoupled instruction-fetch front end for the RISC-V core. It issues word fetches to instruction memory over a req/ack handshake and holds up to two fetched {PC, instruction} pairs in a small FIFO. It presents them to the decode stage over a valid/ready handshake, and it flushes and restarts on branch/jump redirects coming back from execute. It sits between instruction memory and ID, replacing the free-running PC/fetch path.

## Interface
- WIDTH, 64, address/PC width
- RESET_PC, 0, first fetch address after reset
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request; held until acked
- imem_addr  output  WIDTH  fetch address; bits [1:0] always 0
- imem_ack  input  1  completes the pending request at this rising edge; sampled only while imem_req=1
- imem_rdata  input  32  instruction word; valid in the ack cycle
- redirect  input  1  flush and restart fetch
- redirect_pc  input  WIDTH  restart address; bits [1:0] ignored (forced 0)
- id_valid  output  1  head entry available
- id_ready  input  1  decode accepts head entry
- instruction  output  32  head instruction
- PC  output  WIDTH  head PC

## Operation
- Internal state:
  - fetch_pc: next address to request.
  - 2-entry FIFO (rd/wr pointer, count 0..2).
  - FSM with states IDLE, REQ, DRAIN.
- imem_req = (state != IDLE). imem_addr is the registered request address. It is constant while imem_req=1 and not acked.
- id_valid = (count != 0). instruction/PC come from the FIFO head.
- Dequeue occurs when id_valid && id_ready. Enqueue occurs on ack in REQ.
- Let space = (count − deq) < 2, evaluated before this cycle's enqueue.
- IDLE:
  - If redirect: fetch_pc←redirect_pc, flush, then go to REQ.
  - Else if space: latch imem_addr←fetch_pc and go to REQ.
- REQ, no redirect, ack:
  - Enqueue {imem_addr, imem_rdata} and set fetch_pc←imem_addr+4.
  - If the post-update count < 2: imem_addr←imem_addr+4, stay in REQ (back-to-back fetch).
  - Otherwise go to IDLE.
- REQ, no ack: hold.
- REQ, redirect:
  - Flush the FIFO (count←0) and set fetch_pc←redirect_pc.
  - With ack: drop the returning data, imem_addr←redirect_pc, stay in REQ.
  - Without ack: go to DRAIN.
- DRAIN: imem_req stays high with the old address. On ack, discard the data, set imem_addr←fetch_pc and go to REQ. A redirect in DRAIN updates fetch_pc, flushes, and stays in DRAIN.
- Priority: redirect overrides enqueue and dequeue in the same cycle. A dequeue coincident with redirect is still considered taken by ID, but the entry is gone.
- Simultaneous enqueue and dequeue at count=2 is impossible, because no request is issued at count=2. Enqueue and dequeue at count=1 leave count at 1.
- PC arithmetic is modulo 2^WIDTH; 0xFFFF…FFFC+4 wraps to 0.

## Timing
- Reset (async, immediate):
  - Outputs: imem_req=0, imem_addr=0, id_valid=0, instruction=0, PC=0.
  - Internal: state=IDLE, fetch_pc=RESET_PC, count=0.
- First cycle after rst deasserts: IDLE. imem_req rises on the following edge with imem_addr=RESET_PC.
- Fetch latency with zero-wait ack (ack in the first req cycle): id_valid rises the cycle after the ack cycle.
- Throughput: 1 instruction/cycle sustained when ack is always high and id_ready is always high.
- Redirect latency: with a zero-wait ack, the first instruction at the target is valid 2 cycles after the redirect cycle. Add the DRAIN wait if a request was outstanding.
- Valid/data stability:
  - Once id_valid=1, instruction/PC are stable until accepted.
  - The only exceptions are redirect and rst, which may drop id_valid without acceptance.
- Reset mid-request: imem_req drops immediately. Memory must abandon the transaction.

## Test plan
- Reset/startup:
  - Stimulus: RESET_PC=0x100, ack tied high, ready high.
  - Required: PCs 0x100, 0x104, 0x108… one per cycle; instruction equals the modelled imem word.
- Backpressure:
  - Stimulus: id_ready=0 for 10 cycles.
  - Required: exactly 2 entries buffered; imem_req=0 while full. On release, PCs continue without loss or duplication.
- Wait states:
  - Stimulus: ack delayed 3 cycles per request.
  - Required: imem_addr stable while req is high; one instruction every 4 cycles.
- Redirect with outstanding request:
  - Stimulus: redirect to 0x2002 while a req to 0x108 is unacked.
  - Required: next id_valid has PC=0x2000. The 0x108 data is never presented.
- Redirect coincident with ack and dequeue:
  - Required: FIFO empty next cycle, then fetch at the target.
  - Variant: redirect while in DRAIN; required: the last target wins.
- Wrap and async reset:
  - Wrap: fetch from 0xFFFF_FFFF_FFFF_FFFC; required: next PC is 0.
  - Async reset: assert rst between edges; required: all outputs are 0 before the next edge.
